// File: rtl/qpsk_ber_checker_pkg.sv
// Shared definitions for the QPSK BER checker: FSM state encoding,
// reference symbol width and the hard-slicer sign convention.
package qpsk_ber_checker_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        COUNT  = 1'b1
    } state_e;

    // One reference symbol is {ref_I, ref_Q}.
    localparam int unsigned REF_W = 2;

    // A negative sample slices to bit 1; zero and positive samples slice to 0.
    function automatic logic slice_bit(input logic sign_bit);
        return sign_bit;
    endfunction

endpackage

// File: rtl/qpsk_ber_checker_ref_delay_line.sv
// Reference-bit delay line: shifts on enable, tap[0] is the live input and
// tap[k] is the symbol accepted k enables ago. DEPTH must be at least 2.
module ref_delay_line #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 2,
    parameter int unsigned SEL_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] din,
    input  logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] tap
);

    logic [WIDTH-1:0] line_q [1:DEPTH-1];
    logic [WIDTH-1:0] line_d [1:DEPTH-1];

    always_comb begin
        line_d = line_q;
        if (shift_en) begin
            line_d[1] = din;
            for (int unsigned i = 2; i < DEPTH; i++) begin
                line_d[i] = line_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                line_q[i] <= '0;
            end
        end else begin
            line_q <= line_d;
        end
    end

    always_comb begin
        tap = din;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            if (sel == SEL_W'(i)) begin
                tap = line_q[i];
            end
        end
    end

endmodule

// File: rtl/qpsk_ber_checker.sv
// QPSK BER checker: slices rx samples, searches the reference delay that
// aligns them, then counts compared bits and bit errors while locked.
module qpsk_ber_checker
    import qpsk_ber_checker_pkg::*;
#(
    parameter int unsigned DWIDTH    = 16,
    parameter int unsigned MAX_DELAY = 63,
    parameter int unsigned DELAY_W   = 6,
    parameter int unsigned WIN_LEN   = 256,
    parameter int unsigned WIN_W     = 9,
    parameter int unsigned LOCK_THR  = 16,
    parameter int unsigned LOST_THR  = 64,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic                     ref_I,
    input  logic                     ref_Q,
    input  logic signed [DWIDTH-1:0] rx_I,
    input  logic signed [DWIDTH-1:0] rx_Q,
    input  logic                     clr,
    output logic                     locked,
    output logic [DELAY_W-1:0]       delay_est,
    output logic                     search_fail,
    output logic [CNT_W-1:0]         bit_count,
    output logic [CNT_W-1:0]         err_count
);

    // The window sum can reach 2*WIN_LEN, one bit beyond the symbol counter.
    localparam int unsigned SUM_W = WIN_W + 1;

    state_e             state_q, state_d;
    logic [DELAY_W-1:0] delay_q, delay_d;
    logic               search_fail_q, search_fail_d;
    logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
    logic [SUM_W-1:0]   win_sum_q, win_sum_d;
    logic [CNT_W-1:0]   bit_count_q, bit_count_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;

    logic               sym_en;
    logic [REF_W-1:0]   ref_tap;
    logic               rx_i_bit, rx_q_bit;
    logic [1:0]         mism;
    logic [SUM_W-1:0]   sum_next;
    logic               win_end;
    logic [CNT_W:0]     bit_sum, err_sum;
    logic               unused_rx;

    // A cleared cycle drops its sample, so it must not shift the reference.
    assign sym_en = in_valid & ~clr;

    ref_delay_line #(
        .DEPTH(MAX_DELAY + 1),
        .WIDTH(REF_W),
        .SEL_W(DELAY_W)
    ) u_ref_line (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (sym_en),
        .din      ({ref_I, ref_Q}),
        .sel      (delay_q),
        .tap      (ref_tap)
    );

    assign rx_i_bit  = slice_bit(rx_I[DWIDTH-1]);
    assign rx_q_bit  = slice_bit(rx_Q[DWIDTH-1]);
    assign unused_rx = ^{rx_I[DWIDTH-2:0], rx_Q[DWIDTH-2:0]};

    assign mism     = {1'b0, rx_i_bit ^ ref_tap[1]} + {1'b0, rx_q_bit ^ ref_tap[0]};
    assign sum_next = win_sum_q + SUM_W'(mism);
    assign win_end  = sym_en && (win_cnt_q == WIN_W'(WIN_LEN - 1));
    assign bit_sum  = {1'b0, bit_count_q} + (CNT_W + 1)'(2);
    assign err_sum  = {1'b0, err_count_q} + (CNT_W + 1)'(mism);

    always_comb begin
        state_d       = state_q;
        delay_d       = delay_q;
        search_fail_d = search_fail_q;
        win_cnt_d     = win_cnt_q;
        win_sum_d     = win_sum_q;
        bit_count_d   = bit_count_q;
        err_count_d   = err_count_q;

        if (clr) begin
            state_d       = SEARCH;
            delay_d       = '0;
            search_fail_d = 1'b0;
            win_cnt_d     = '0;
            win_sum_d     = '0;
            bit_count_d   = '0;
            err_count_d   = '0;
        end else if (in_valid) begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
            win_sum_d = sum_next;

            if (state_q == COUNT) begin
                bit_count_d = bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
                err_count_d = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
            end

            if (win_end) begin
                win_cnt_d = '0;
                win_sum_d = '0;
                if (state_q == SEARCH) begin
                    if (sum_next <= SUM_W'(LOCK_THR)) begin
                        state_d = COUNT;
                    end else if (delay_q == DELAY_W'(MAX_DELAY)) begin
                        delay_d       = '0;
                        search_fail_d = 1'b1;
                    end else begin
                        delay_d = delay_q + DELAY_W'(1);
                    end
                end else if (sum_next > SUM_W'(LOST_THR)) begin
                    state_d = SEARCH;
                    delay_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= SEARCH;
            delay_q       <= '0;
            search_fail_q <= 1'b0;
            win_cnt_q     <= '0;
            win_sum_q     <= '0;
            bit_count_q   <= '0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            delay_q       <= delay_d;
            search_fail_q <= search_fail_d;
            win_cnt_q     <= win_cnt_d;
            win_sum_q     <= win_sum_d;
            bit_count_q   <= bit_count_d;
            err_count_q   <= err_count_d;
        end
    end

    assign locked      = (state_q == COUNT);
    assign delay_est   = delay_q;
    assign search_fail = search_fail_q;
    assign bit_count   = bit_count_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_qpsk_ber_checker.sv
// Scoreboard bench for qpsk_ber_checker: random symbols through a delayed
// channel, compared against a symbol-level reference model.
module tb_qpsk_ber_checker;

    localparam int unsigned WIN_LEN   = 256;
    localparam int unsigned MAX_DELAY = 63;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               ref_I = 1'b0;
    logic               ref_Q = 1'b0;
    logic               clr = 1'b0;
    logic signed [15:0] rx_I = '0;
    logic signed [15:0] rx_Q = '0;

    logic        locked, search_fail;
    logic [5:0]  delay_est;
    logic [31:0] bit_count, err_count;
    logic        locked4, search_fail4;
    logic [5:0]  delay_est4;
    logic [3:0]  bit_count4, err_count4;

    qpsk_ber_checker u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .ref_I(ref_I), .ref_Q(ref_Q),
        .rx_I(rx_I), .rx_Q(rx_Q), .clr(clr), .locked(locked), .delay_est(delay_est),
        .search_fail(search_fail), .bit_count(bit_count), .err_count(err_count)
    );

    qpsk_ber_checker #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .ref_I(ref_I), .ref_Q(ref_Q),
        .rx_I(rx_I), .rx_Q(rx_Q), .clr(clr), .locked(locked4), .delay_est(delay_est4),
        .search_fail(search_fail4), .bit_count(bit_count4), .err_count(err_count4)
    );

    typedef struct {
        logic   lk;
        int     d;
        logic   sf;
        longint bc;
        longint ec;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: symbol-level view of the measurement rules.
    logic       m_locked = 1'b0;
    int         m_d = 0;
    logic       m_sf = 1'b0;
    longint     m_bc = 0, m_ec = 0;
    int         m_wcnt = 0, m_wsum = 0;
    logic [1:0] m_hist[$];

    // Channel: rx = reference delayed by ch_delay accepted symbols.
    logic [1:0] ch_hist[$];
    int         ch_delay = 0;
    bit         rx_random = 1'b0;
    int         flip_period = 0;
    int         flip_cnt = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at %0t: got=%0d expected=%0d", name, $time, got, exp);
        end
    endtask

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic signed [15:0] mk_sample(input logic b);
        int unsigned mag;
        mag = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 20000);
        if (b) return 16'(-int'($urandom_range(1, 20000)));
        return 16'(mag);
    endfunction

    task automatic model_step(input logic rst, input logic c, input logic v,
                              input logic [1:0] r, input logic [1:0] rxb);
        logic [1:0] tp;
        int         mm;
        if (!rst) begin
            m_locked = 1'b0; m_d = 0; m_sf = 1'b0; m_bc = 0; m_ec = 0;
            m_wcnt = 0; m_wsum = 0; m_hist.delete();
            return;
        end
        if (c) begin
            m_locked = 1'b0; m_d = 0; m_sf = 1'b0; m_bc = 0; m_ec = 0;
            m_wcnt = 0; m_wsum = 0;
            return;
        end
        if (!v) return;
        if (m_d == 0)                 tp = r;
        else if (m_d <= m_hist.size()) tp = m_hist[m_d-1];
        else                          tp = 2'b00;
        mm = int'(rxb[1] ^ tp[1]) + int'(rxb[0] ^ tp[0]);
        if (m_locked) begin
            m_bc += 2;
            m_ec += mm;
        end
        m_wcnt++;
        m_wsum += mm;
        if (m_wcnt == WIN_LEN) begin
            if (!m_locked) begin
                if (m_wsum <= 16)          m_locked = 1'b1;
                else if (m_d == MAX_DELAY) begin m_d = 0; m_sf = 1'b1; end
                else                       m_d++;
            end else if (m_wsum > 64) begin
                m_locked = 1'b0;
                m_d = 0;
            end
            m_wcnt = 0;
            m_wsum = 0;
        end
        m_hist.push_front(r);
        if (m_hist.size() > MAX_DELAY + 1) void'(m_hist.pop_back());
    endtask

    task automatic tick(input logic rst, input logic c, input logic v);
        logic [1:0] r, rxb;
        exp_t       e;
        @(negedge clk);
        r = 2'($urandom);
        if (rx_random) begin
            rxb = 2'($urandom);
        end else begin
            if (ch_delay == 0)                  rxb = r;
            else if (ch_delay <= ch_hist.size()) rxb = ch_hist[ch_delay-1];
            else                                rxb = 2'b00;
            if (flip_period != 0 && rst && v && !c) begin
                if (flip_cnt % flip_period == 0) rxb[1] = ~rxb[1];
                flip_cnt++;
            end
        end
        rst_n = rst; clr = c; in_valid = v;
        ref_I = r[1]; ref_Q = r[0];
        rx_I = mk_sample(rxb[1]);
        rx_Q = mk_sample(rxb[0]);
        if (!rst) begin
            ch_hist.delete();
        end else if (v && !c) begin
            ch_hist.push_front(r);
            if (ch_hist.size() > MAX_DELAY + 1) void'(ch_hist.pop_back());
        end
        model_step(rst, c, v, r, rxb);
        e.lk = m_locked; e.d = m_d; e.sf = m_sf; e.bc = m_bc; e.ec = m_ec;
        sb_q.push_back(e);
    endtask

    task automatic idle();
        tick(1'b1, 1'b0, 1'b0);
    endtask

    // Issues n accepted symbols with random stalls, bounded in cycles.
    task automatic run_syms(input int n, input int pct);
        int acc, cyc;
        logic v;
        acc = 0; cyc = 0;
        while (acc < n && cyc < 4 * n + 100) begin
            v = (pct >= 100) || (int'($urandom_range(0, 99)) < pct);
            tick(1'b1, 1'b0, v);
            if (v) acc++;
            cyc++;
        end
        chk("run_syms_budget", acc, n);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("sb_locked", locked, e.lk);
                chk("sb_delay_est", delay_est, e.d);
                chk("sb_search_fail", search_fail, e.sf);
                chk("sb_bit_count", bit_count, sat(e.bc, 32));
                chk("sb_err_count", err_count, sat(e.ec, 32));
                chk("sb_bit_count4", bit_count4, sat(e.bc, 4));
                chk("sb_err_count4", err_count4, sat(e.ec, 4));
            end
        end
    end

    initial begin
        int wait_cyc;

        // Reset with in_valid asserted
        repeat (3) tick(1'b0, 1'b0, 1'b1);
        idle();
        chk("rst_locked", locked, 0);
        chk("rst_delay_est", delay_est, 0);
        chk("rst_search_fail", search_fail, 0);
        chk("rst_bit_count", bit_count, 0);
        chk("rst_err_count", err_count, 0);

        // Noiseless loopback at delay 17, continuous valid
        ch_delay = 17;
        run_syms(18 * WIN_LEN - 1, 100);
        idle();
        chk("t1_not_locked_early", locked, 0);
        run_syms(1, 100);
        idle();
        chk("t1_locked", locked, 1);
        chk("t1_delay_est", delay_est, 17);
        run_syms(40, 100);
        idle();
        chk("t1_bit_count", bit_count, 80);
        chk("t1_err_count", err_count, 0);
        chk("t5_bit_count4_sat", bit_count4, 15);
        run_syms(2 * WIN_LEN, 70);
        idle();
        chk("t1_err_count_long", err_count, 0);
        chk("t1_still_locked", locked, 1);
        chk("t5_bit_count4_hold", bit_count4, 15);

        // Uncorrelated rx: full sweep fails
        tick(1'b1, 1'b1, 1'b1);
        rx_random = 1'b1;
        run_syms(64 * WIN_LEN, 85);
        idle();
        chk("t2_locked", locked, 0);
        chk("t2_search_fail", search_fail, 1);
        chk("t2_delay_wrap", delay_est, 0);

        // Lock at delay 5, then one flipped bit every 4 symbols
        tick(1'b1, 1'b1, 1'b0);
        idle();
        chk("t3_clr_search_fail", search_fail, 0);
        rx_random = 1'b0;
        ch_delay = 5;
        run_syms(6 * WIN_LEN, 85);
        idle();
        chk("t3_locked", locked, 1);
        chk("t3_delay_est", delay_est, 5);
        flip_period = 4;
        flip_cnt = 0;
        run_syms(4 * WIN_LEN, 85);
        idle();
        chk("t3_bit_count", bit_count, 2 * 4 * WIN_LEN);
        chk("t3_err_count", err_count, WIN_LEN);
        chk("t3_lock_held", locked, 1);

        // Realign channel to delay 8: lose lock after one window, relock
        flip_period = 0;
        ch_delay = 8;
        run_syms(WIN_LEN - 1, 85);
        idle();
        chk("t4_locked_before_end", locked, 1);
        run_syms(1, 100);
        idle();
        chk("t4_lost", locked, 0);
        chk("t4_delay_reset", delay_est, 0);
        chk("t4_bit_count_held", bit_count, 2 * 5 * WIN_LEN);
        run_syms(9 * WIN_LEN, 85);
        idle();
        chk("t4_relocked", locked, 1);
        chk("t4_relock_delay", delay_est, 8);
        chk("t4_bit_count_after_relock", bit_count, 2 * 5 * WIN_LEN);

        // clr together with in_valid mid-COUNT
        run_syms(37, 85);
        tick(1'b1, 1'b1, 1'b1);
        idle();
        chk("t6_locked", locked, 0);
        chk("t6_delay_est", delay_est, 0);
        chk("t6_bit_count", bit_count, 0);
        chk("t6_err_count", err_count, 0);
        run_syms(9 * WIN_LEN, 85);
        idle();
        chk("t6_relocked", locked, 1);
        chk("t6_relock_delay", delay_est, 8);

        // Reset mid-window discards everything
        run_syms(100, 85);
        tick(1'b0, 1'b0, 1'b1);
        idle();
        chk("rst2_locked", locked, 0);
        chk("rst2_bit_count", bit_count, 0);

        wait_cyc = 0;
        while (sb_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        #2;
        chk("sb_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
